ddcq_derotator: RTL and testbench



---
 rtl/ddcq_pkg.sv | 32 +++
 rtl/ddcq_if.sv | 8 +
 rtl/ddcq_cordic_stage.sv | 22 ++
 rtl/ddcq_derotator.sv | 94 +++++++++
 tb/tb_ddcq_derotator.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ddcq_pkg.sv
// ddcq_pkg: shared widths, CORDIC arctangent table, gain constant, FSM states and rounding helpers.
package ddcq_pkg;
  localparam int SW = 14;
  localparam int FB = 11;
  localparam int ITER = 12;
  localparam int GB = 3;
  localparam int DW = SW + 2 + GB;
  localparam int ZW = 16;
  localparam int PW = 30;
  localparam int SMAX = 2 ** (SW - 1) - 1;
  localparam int SMIN = -(2 ** (SW - 1));
  localparam logic [11:0] GAIN = 12'h9B7;
  localparam logic signed [ZW-1:0] ATAN_TAB [ITER] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326,
    16'sd163, 16'sd81, 16'sd41, 16'sd20, 16'sd10, 16'sd5
  };
  typedef enum logic [1:0] {S_IDLE, S_PREROT, S_ITER, S_POST} state_t;
  function automatic logic signed [DW-1:0] gain_mul(input logic signed [DW-1:0] v);
    logic signed [DW+12:0] acc;
    acc = '0;
    for (int k = 0; k < 12; k++)
      if (GAIN[k]) acc = acc + ($signed({{13{v[DW-1]}}, v}) <<< k);
    return DW'(acc >>> 12);
  endfunction
  // Round half-up away the guard bits, then clamp into the Q3.11 range.
  function automatic logic signed [SW-1:0] rnd_sat(input logic signed [DW-1:0] v);
    logic signed [DW:0] w;
    w = {v[DW-1], v} + (DW+1)'(1 << (GB - 1));
    w = w >>> GB;
    return w > SMAX ? SW'(SMAX) : w < SMIN ? SW'(SMIN) : SW'(w);
  endfunction
endpackage

// File: rtl/ddcq_if.sv
// ddcq_if: sample/strobe bus between the receive front-end and the derotator.
interface ddcq_if;
  logic signed [ddcq_pkg::SW-1:0] i_x, i_y, o_x, o_y;
  logic [ddcq_pkg::PW-1:0] i_ddcfreq;
  logic i_start, o_done, o_busy;
  modport master (output i_x, i_y, i_start, i_ddcfreq, input o_x, o_y, o_done, o_busy);
  modport slave (input i_x, i_y, i_start, i_ddcfreq, output o_x, o_y, o_done, o_busy);
endinterface

// File: rtl/ddcq_cordic_stage.sv
// ddcq_cordic_stage: one combinational CORDIC micro-rotation driven toward z = 0.
module ddcq_cordic_stage
  import ddcq_pkg::*;
(
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic [3:0] i_i,
  input  logic signed [ZW-1:0] i_atan,
  output logic signed [DW-1:0] o_x,
  output logic signed [DW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);
  logic w_neg;
  logic signed [DW-1:0] w_xs, w_ys;
  assign w_neg = i_z[ZW-1];
  assign w_xs = i_x >>> i_i;
  assign w_ys = i_y >>> i_i;
  assign o_x = w_neg ? i_x + w_ys : i_x - w_ys;
  assign o_y = w_neg ? i_y - w_xs : i_y + w_xs;
  assign o_z = w_neg ? i_z + i_atan : i_z - i_atan;
endmodule

// File: rtl/ddcq_derotator.sv
// ddcq_derotator: NCO + iterative CORDIC rotating each I/Q sample by minus the NCO phase.
// Define DDCQ_GAINCOMP_EN to cancel the CORDIC gain in the POST cycle.
module ddcq_derotator
  import ddcq_pkg::*;
(
  input logic clk,
  input logic reset_n,
  ddcq_if.slave bus
);
  state_t r_state, w_next;
  logic [PW-1:0] r_phacc;
  logic [11:0] r_theta;
  logic signed [SW-1:0] r_xin, r_yin, r_ox, r_oy;
  logic signed [DW-1:0] r_x, r_y;
  logic signed [ZW-1:0] r_z, w_sz;
  logic [3:0] r_cnt;
  logic r_busy, r_done, w_accept;
  logic [1:0] w_q;
  logic signed [DW-1:0] w_xe, w_ye, w_xq, w_yq, w_sx, w_sy, w_gx, w_gy;
  assign w_accept = bus.i_start && !r_busy;
  assign w_q = r_theta[11:10];
  assign w_xe = {{2{r_xin[SW-1]}}, r_xin, {GB{1'b0}}};
  assign w_ye = {{2{r_yin[SW-1]}}, r_yin, {GB{1'b0}}};
  assign w_xq = w_q == 2'd0 ? w_xe : w_q == 2'd1 ? -w_ye : w_q == 2'd2 ? -w_xe : w_ye;
  assign w_yq = w_q == 2'd0 ? w_ye : w_q == 2'd1 ? w_xe : w_q == 2'd2 ? -w_ye : -w_xe;
`ifdef DDCQ_GAINCOMP_EN
  assign w_gx = gain_mul(r_x);
  assign w_gy = gain_mul(r_y);
`else
  assign w_gx = r_x;
  assign w_gy = r_y;
`endif
  ddcq_cordic_stage u_stage (
    .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_i(r_cnt), .i_atan(ATAN_TAB[r_cnt]),
    .o_x(w_sx), .o_y(w_sy), .o_z(w_sz)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_accept ? S_PREROT : S_IDLE;
      S_PREROT: w_next = S_ITER;
      S_ITER:   w_next = r_cnt == 4'(ITER - 1) ? S_POST : S_ITER;
      default:  w_next = S_IDLE;
    endcase
  end
  // o_busy stays high through the o_done cycle, which is what blocks a start there.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_phacc <= '0;
      r_theta <= '0;
      r_xin <= '0;
      r_yin <= '0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ox <= '0;
      r_oy <= '0;
    end else begin
      r_done <= r_state == S_POST;
      if (w_accept) begin
        r_phacc <= r_phacc + bus.i_ddcfreq;
        r_theta <= -r_phacc[PW-1:PW-12];
        r_xin <= bus.i_x;
        r_yin <= bus.i_y;
        r_busy <= 1'b1;
      end else if (r_done) r_busy <= 1'b0;
      if (r_state == S_PREROT) begin
        r_x <= w_xq;
        r_y <= w_yq;
        r_z <= $signed({2'b00, r_theta[9:0], 4'b0000});
        r_cnt <= '0;
      end
      if (r_state == S_ITER) begin
        r_x <= w_sx;
        r_y <= w_sy;
        r_z <= w_sz;
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_POST) begin
        r_ox <= rnd_sat(w_gx);
        r_oy <= rnd_sat(w_gy);
      end
    end
  assign bus.o_x = r_ox;
  assign bus.o_y = r_oy;
  assign bus.o_done = r_done;
  assign bus.o_busy = r_busy;
endmodule

// File: tb/tb_ddcq_derotator.sv
// tb_ddcq_derotator: directed vectors with a scoreboard queue checked by an independent done monitor.
module tb_ddcq_derotator;
  typedef struct packed {int ex; int ey; int tx; int ty; int t0;} exp_t;
`ifdef DDCQ_GAINCOMP_EN
  localparam real G = 1.0;
`else
  localparam real G = 1.6467602;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  string nq[$];
  exp_t m_e;
  string m_nm;
  ddcq_if bus();
  ddcq_derotator dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string nm, int act, int req, int tol);
    n_tests++;
    if (act > req + tol || act < req - tol) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d (tol %0d)", nm, act, req, tol);
    end
  endtask
  function automatic int sat(real v);
    int r;
    r = int'(v);
    return r > 8191 ? 8191 : r < -8192 ? -8192 : r;
  endfunction
  task automatic push(string nm, int x, int y, real deg, int tx, int ty, int t0);
    real a;
    exp_t e;
    a = deg * 3.14159265358979 / 180.0;
    e.ex = sat(G * (x * $cos(a) - y * $sin(a)));
    e.ey = sat(G * (x * $sin(a) + y * $cos(a)));
    e.tx = tx;
    e.ty = ty;
    e.t0 = t0;
    sb.push_back(e);
    nq.push_back(nm);
  endtask
  task automatic issue(string nm, int x, int y, logic [29:0] f, real deg, int tx, int ty);
    @(negedge clk);
    bus.i_x = 14'(x);
    bus.i_y = 14'(y);
    bus.i_ddcfreq = f;
    bus.i_start = 1'b1;
    push(nm, x, y, deg, tx, ty, cyc);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_busy && n < 40);
    if (bus.o_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout got busy=%0b required 0 within 40 cycles", bus.o_busy);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.o_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done got x=%0d y=%0d required no result", bus.o_x, bus.o_y);
      end else begin
        m_e = sb.pop_front();
        m_nm = nq.pop_front();
        check({m_nm, "_x"}, bus.o_x, m_e.ex, m_e.tx);
        check({m_nm, "_y"}, bus.o_y, m_e.ey, m_e.ty);
        check({m_nm, "_lat"}, cyc - m_e.t0, 15, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no finish required completion by 200000");
    $fatal(1);
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_x = '0;
    bus.i_y = '0;
    bus.i_ddcfreq = '0;
    repeat (3) @(negedge clk);
    check("rst_ox", bus.o_x, 0, 0);
    check("rst_oy", bus.o_y, 0, 0);
    check("rst_done", int'(bus.o_done), 0, 0);
    check("rst_busy", int'(bus.o_busy), 0, 0);
    reset_n = 1'b1;
    issue("dc", 2048, 0, 30'h0, 0.0, 3, 3);
    wait_idle();
    do_reset();
    issue("q0", 2048, 0, 30'h1000_0000, 0.0, 3, 3);
    wait_idle();
    issue("q1", 2048, 0, 30'h1000_0000, -90.0, 3, 3);
    wait_idle();
    issue("q2", 2048, 0, 30'h1000_0000, -180.0, 3, 3);
    wait_idle();
    issue("q3", 2048, 0, 30'h1000_0000, -270.0, 3, 3);
    wait_idle();
    do_reset();
    @(negedge clk);
    bus.i_x = 14'sd2048;
    bus.i_y = '0;
    bus.i_ddcfreq = 30'h1000_0000;
    bus.i_start = 1'b1;
    push("burst0", 2048, 0, 0.0, 3, 3, cyc);
    push("burst1", 2048, 0, -90.0, 3, 3, cyc + 16);
    repeat (30) @(negedge clk);
    bus.i_start = 1'b0;
    wait_idle();
    issue("burst_phase", 2048, 0, 30'h0, -180.0, 3, 3);
    wait_idle();
    do_reset();
    issue("sat0", 0, 0, 30'h0800_0000, 0.0, 3, 3);
    wait_idle();
    issue("sat", 7987, 7987, 30'h0, -45.0, 0, 8);
    wait_idle();
    issue("abort", 2048, 0, 30'h1000_0000, 0.0, 3, 3);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    void'(sb.pop_back());
    void'(nq.pop_back());
    #1;
    check("abort_ox", bus.o_x, 0, 0);
    check("abort_oy", bus.o_y, 0, 0);
    check("abort_done", int'(bus.o_done), 0, 0);
    check("abort_busy", int'(bus.o_busy), 0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    issue("post_rst", 2048, 0, 30'h1000_0000, 0.0, 3, 3);
    wait_idle();
    do_reset();
    issue("wrap0", 2048, 0, 30'h3FFF_FFFF, 0.0, 3, 3);
    wait_idle();
    for (int k = 1; k < 4; k++) begin
      issue($sformatf("wrap%0d", k), 2048, 0, 30'h3FFF_FFFF, 360.0 / 4096.0, 3, 3);
      wait_idle();
    end
    issue("wrap_phase", 2048, 0, 30'h0, 360.0 / 4096.0, 3, 3);
    wait_idle();
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
